// File: rtl/sha2_pkg.sv
// sha2_pkg: shared definitions for the SHA-2 round-constant stream.
//   K512       - the 80 SHA-384/512 round constants (FIPS 180-4). The upper
//                32 bits of entries 0..63 are the SHA-224/256 constants.
//   ROUNDS_256 - rounds per block for 32-bit words.
//   ROUNDS_512 - rounds per block for 64-bit words.
//   IDLE/RUN   - stream FSM state encoding.
package sha2_pkg;

    localparam int ROUNDS_256 = 64;
    localparam int ROUNDS_512 = 80;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [63:0] K512 [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

endpackage

// File: rtl/sha2_k_rom.sv
// sha2_k_rom: combinational K512 lookup.
//   idx - round index 0..79
//   k   - 64-bit round constant, zero for idx >= 80
module sha2_k_rom
    import sha2_pkg::*;
(
    input  logic [6:0]  idx,
    output logic [63:0] k
);

    always_comb begin
        k = '0;
        if (idx < 7'd80) begin
            k = K512[idx];
        end
    end

endmodule

// File: rtl/sha2_kt_stream.sv
// sha2_kt_stream: registered, handshaked stream of SHA-2 round constants.
//   i_clk, i_rst     - clock, synchronous active-high reset
//   i_start, i_abort - begin a sequence at round 0 / drop the current one
//   i_ready          - consumer takes the presented constant this cycle
//   o_valid, o_kt    - constant valid, K_t (upper half of K512 for 32-bit)
//   o_round, o_last  - round index t, flag for the final round
//   o_busy           - sequence in progress
module sha2_kt_stream
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [WORD_W-1:0] o_kt,
    output logic [6:0]        o_round,
    output logic              o_last,
    output logic              o_busy
);

    localparam int         ROUNDS     = (WORD_W == 64) ? ROUNDS_512 : ROUNDS_256;
    localparam logic [6:0] LAST_ROUND = 7'(ROUNDS - 1);

    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
        $error("sha2_kt_stream: WORD_W must be 32 or 64");
    end

    logic [0:0]        state_q, state_d;
    logic              valid_d;
    logic [6:0]        round_d;
    logic              last_q;
    logic              accept;
    logic [63:0]       rom_k;
    logic [WORD_W-1:0] kt_d;

    assign accept = o_valid & i_ready;

    // Next-state and next-index selection; abort beats start and accept.
    always_comb begin
        state_d = state_q;
        valid_d = o_valid;
        round_d = o_round;
        if (i_abort) begin
            state_d = IDLE;
            valid_d = 1'b0;
            round_d = '0;
        end else if (state_q == IDLE) begin
            if (i_start) begin
                state_d = RUN;
                valid_d = 1'b1;
                round_d = '0;
            end
        end else if (accept) begin
            if (o_round == LAST_ROUND) begin
                // A start on the final accept restarts with no bubble.
                round_d = '0;
                if (!i_start) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end else begin
                round_d = o_round + 7'd1;
            end
        end
    end

    // Look up the constant for the index being registered, so o_kt and
    // o_round always change on the same edge.
    sha2_k_rom u_rom (
        .idx (round_d),
        .k   (rom_k)
    );

    assign kt_d = valid_d ? rom_k[63 -: WORD_W] : '0;

    if (WORD_W < 64) begin : g_low_half
        logic unused_low;
        assign unused_low = ^rom_k[63-WORD_W:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            o_valid <= 1'b0;
            o_kt    <= '0;
            o_round <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            o_valid <= valid_d;
            o_kt    <= kt_d;
            o_round <= round_d;
            last_q  <= valid_d && (round_d == LAST_ROUND);
        end
    end

    assign o_last = last_q;
    assign o_busy = (state_q == RUN);

endmodule

// File: doc/sha2_kt_stream.md
# sha2_kt_stream

Sequenced round-constant source for the SHA-2 compression datapath. It replaces a purely combinational constant lookup with a counter-driven, registered stream of K_t words under a valid/ready handshake. One parameter covers both the SHA-224/256 family (32-bit words, 64 rounds) and the SHA-384/512 family (64-bit words, 80 rounds). It sits between the block controller, which issues start and abort, and the round engine, which consumes one K_t per accepted round.

## Interface
Parameters:
- WORD_W, 32: constant width. Legal values are 32 (SHA-256 family) and 64 (SHA-512 family). Any other value is an elaboration error.
- ROUNDS, derived and not overridable: 64 when WORD_W=32, 80 when WORD_W=64.

Ports:
- i_clk  in  1  sole clock; all state changes on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  begin a constant sequence at round 0.
- i_abort  in  1  terminate the current sequence.
- i_ready  in  1  consumer accepts the presented K_t this cycle.
- o_valid  out  1  o_kt/o_round hold a valid constant.
- o_kt  out  WORD_W  round constant K_t.
- o_round  out  7  round index t.
- o_last  out  1  high when o_valid is high and o_round = ROUNDS-1.
- o_busy  out  1  high in state RUN.

## Operation
- Two states, IDLE and RUN. All outputs are registered.
- IDLE:
  - i_start=1 moves to RUN. Next cycle: o_valid=1, o_round=0, o_kt=K_0.
  - i_ready is ignored.
- RUN:
  - An accept is o_valid & i_ready.
  - Accept with o_round<ROUNDS-1: o_round increments, o_kt loads K_(t+1).
  - No accept: o_kt, o_round and o_valid hold stable.
  - Accept with o_round=ROUNDS-1:
    - i_start=0: go to IDLE; o_valid=0 next cycle.
    - i_start=1: back-to-back restart; stay in RUN with o_round=0, o_kt=K_0 next cycle, no bubble.
  - i_start while in RUN, other than on the final accept, is ignored.
- i_abort=1 in any state: next state IDLE, o_valid=0, o_round=0, o_kt=0. i_abort has priority over i_start and over an accept.
- Constant source: one 80×64-bit table. For WORD_W=64, o_kt=K512[t]. For WORD_W=32, o_kt=K512[t][63:32]; the upper halves of the first 64 SHA-512 constants are exactly the SHA-256 constants.
- o_round is 7 bits. It never exceeds ROUNDS-1 and never wraps past it.
- Reset values: o_valid=0, o_kt=0, o_round=0, o_last=0, o_busy=0, state IDLE. Reset has priority over everything, including a reset asserted mid-sequence.

## Timing
- Start latency: i_start sampled high in IDLE gives o_valid=1 on the next edge.
- Throughput: one constant per cycle while i_ready is held high.
  - Full sequence: 64 cycles (WORD_W=32) or 80 cycles (WORD_W=64) from first valid to last accept.
- Advance latency: an accept at edge n presents K_(t+1) after edge n.
- o_last is combinationally equal to a registered flag set together with o_round=ROUNDS-1. It is not computed from i_ready.
- Abort and reset take effect after one edge. No partial outputs follow.

## Structure
- Package sha2_pkg holds:
  - the 80-entry 64-bit K512 constant array;
  - ROUNDS_256=64 and ROUNDS_512=80;
  - the state encoding, IDLE=1'b0 and RUN=1'b1.
- Sub-module sha2_k_rom: combinational lookup of the package array, 7-bit index in, 64-bit word out, 0 for index ≥80.
- The top level holds the FSM, index counter, output registers and WORD_W slicing.

## Test plan
- WORD_W=32, reset then i_start pulse, i_ready=1:
  - first beat o_round=0, o_kt=32'h428a2f98; second beat o_kt=32'h71374491;
  - beat 64 o_kt=32'hc67178f2 with o_last=1; o_valid=0 the cycle after.
- WORD_W=64, same stimulus:
  - o_kt=64'h428a2f98d728ae22, then 64'h7137449123ef65cd;
  - round 79 o_kt=64'h6c44198c4a475817 with o_last=1; exactly 80 beats.
- Backpressure: i_ready=0 for 5 cycles at round 10. o_round=10 and o_kt=K_10 stay stable; the sequence resumes at 11 with no skipped or duplicated rounds.
- Back-to-back: i_start=1 on the final accept cycle. The next cycle shows o_round=0, o_kt=K_0 and o_valid stays 1. An i_start at round 20 is ignored.
- Abort at round 30 with i_ready=1 and i_start=1 in the same cycle. Next cycle o_valid=0, o_busy=0, o_round=0; a later i_start begins at round 0.
- i_rst asserted at round 40 for one cycle. All outputs read their reset values the next cycle. The scoreboard matches every accepted K_t against the FIPS 180-4 table for both widths.
